// File: rtl/ahb_mux_n.sv
// AHB-Lite response multiplexor for N slaves: registers the address-phase select
// and routes the owning slave (or an internal ERROR-only default slave) to the master.
module ahb_mux_n #(
  parameter int AHB_DATA_WIDTH = 32,
  parameter int SLAVE_DEVICES  = 4,
  localparam int SLAVE_IDX_W   = (SLAVE_DEVICES > 1) ? $clog2(SLAVE_DEVICES) : 1
) (
  input  logic                                    ahb_clk_in,
  input  logic                                    ahb_rstn_in,
  input  logic [SLAVE_DEVICES-1:0]                decoder_sel_in,
  input  logic [1:0]                              ahb_htrans_in,
  input  logic [SLAVE_DEVICES*AHB_DATA_WIDTH-1:0] slave_rdata_in,
  input  logic [SLAVE_DEVICES-1:0]                slave_readyout_in,
  input  logic [SLAVE_DEVICES-1:0]                slave_resp_in,
  output logic [AHB_DATA_WIDTH-1:0]               ahb_rdata_out,
  output logic                                    ahb_ready_out,
  output logic                                    ahb_resp_out,
  output logic                                    sel_error_out
);

  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_SLAVE = 2'd1,
    D_ERR1  = 2'd2,
    D_ERR2  = 2'd3
  } dstate_e;

  dstate_e                  state_q, state_d;
  logic [SLAVE_IDX_W-1:0]   sidx_q, sidx_d;
  logic                     sel_error_q, sel_error_d;

  logic [4:0]               sel_cnt;
  logic [SLAVE_IDX_W-1:0]   sel_idx;
  logic                     xfer_active;
  logic [AHB_DATA_WIDTH-1:0] slv_rdata;
  logic                     slv_ready;
  logic                     slv_resp;

  // NONSEQ and SEQ are the only transfer types that open a data phase.
  assign xfer_active = (ahb_htrans_in == 2'b10) || (ahb_htrans_in == 2'b11);

  always_comb begin
    sel_cnt = '0;
    sel_idx = '0;
    for (int i = 0; i < SLAVE_DEVICES; i++) begin
      if (decoder_sel_in[i]) begin
        sel_cnt = sel_cnt + 5'd1;
        sel_idx = SLAVE_IDX_W'(i);
      end
    end
  end

  always_comb begin
    slv_rdata = '0;
    slv_ready = 1'b1;
    slv_resp  = 1'b0;
    for (int i = 0; i < SLAVE_DEVICES; i++) begin
      if (sidx_q == SLAVE_IDX_W'(i)) begin
        slv_rdata = slave_rdata_in[i*AHB_DATA_WIDTH +: AHB_DATA_WIDTH];
        slv_ready = slave_readyout_in[i];
        slv_resp  = slave_resp_in[i];
      end
    end
  end

  always_comb begin
    ahb_rdata_out = '0;
    ahb_ready_out = 1'b1;
    ahb_resp_out  = 1'b0;
    case (state_q)
      D_SLAVE: begin
        ahb_rdata_out = slv_rdata;
        ahb_ready_out = slv_ready;
        ahb_resp_out  = slv_resp;
      end
      D_ERR1: begin
        ahb_ready_out = 1'b0;
        ahb_resp_out  = 1'b1;
      end
      D_ERR2: begin
        ahb_ready_out = 1'b1;
        ahb_resp_out  = 1'b1;
      end
      default: ;
    endcase
  end

  // A sample edge is any edge seen with HREADY high; it replaces the data phase outright.
  always_comb begin
    state_d     = state_q;
    sidx_d      = sidx_q;
    sel_error_d = 1'b0;
    if (ahb_ready_out) begin
      if (!xfer_active) begin
        state_d = D_IDLE;
      end else if (sel_cnt == 5'd1) begin
        state_d = D_SLAVE;
        sidx_d  = sel_idx;
      end else begin
        state_d     = D_ERR1;
        sel_error_d = (sel_cnt > 5'd1);
      end
    end else if (state_q == D_ERR1) begin
      state_d = D_ERR2;
    end
  end

  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) begin
      state_q     <= D_IDLE;
      sidx_q      <= '0;
      sel_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sidx_q      <= sidx_d;
      sel_error_q <= sel_error_d;
    end
  end

  assign sel_error_out = sel_error_q;

endmodule

// File: tb/tb_ahb_mux_n.sv
// Bench for ahb_mux_n: directed scenarios with literal expectations plus random traffic,
// all cross-checked every cycle against an ownership/response-queue model.
module tb_ahb_mux_n;
  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rstn;
  logic [N-1:0]   sel;
  logic [1:0]     htrans;
  logic [N*W-1:0] rdata_in;
  logic [N-1:0]   rdy_in;
  logic [N-1:0]   resp_in;
  logic [W-1:0]   rdata_o;
  logic           ready_o;
  logic           resp_o;
  logic           selerr_o;

  ahb_mux_n #(.AHB_DATA_WIDTH(W), .SLAVE_DEVICES(N)) dut (
    .ahb_clk_in        (clk),
    .ahb_rstn_in       (rstn),
    .decoder_sel_in    (sel),
    .ahb_htrans_in     (htrans),
    .slave_rdata_in    (rdata_in),
    .slave_readyout_in (rdy_in),
    .slave_resp_in     (resp_in),
    .ahb_rdata_out     (rdata_o),
    .ahb_ready_out     (ready_o),
    .ahb_resp_out      (resp_o),
    .sel_error_out     (selerr_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: who owns the data phase (-1 none, 0..N-1 a slave, N the default slave)
  // and the beats the default slave still owes, as {ready, resp}.
  int         owner = -1;
  logic [1:0] dflt_q[$];
  logic       exp_pulse = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    logic [W-1:0] e_rdata;
    logic         e_ready;
    logic         e_resp;
    int           cnt;
    int           idx;
    if (!rstn) begin
      owner     = -1;
      dflt_q.delete();
      exp_pulse = 1'b0;
      chk("rst_rdata", rdata_o, '0);
      chk("rst_ready", W'(ready_o), W'(1));
      chk("rst_resp", W'(resp_o), W'(0));
      chk("rst_selerr", W'(selerr_o), W'(0));
    end else begin
      e_rdata = '0;
      e_ready = 1'b1;
      e_resp  = 1'b0;
      if (owner == N && dflt_q.size() > 0) begin
        e_ready = dflt_q[0][1];
        e_resp  = dflt_q[0][0];
      end else if (owner >= 0 && owner < N) begin
        e_rdata = rdata_in[owner*W +: W];
        e_ready = rdy_in[owner];
        e_resp  = resp_in[owner];
      end
      chk("mdl_rdata", rdata_o, e_rdata);
      chk("mdl_ready", W'(ready_o), W'(e_ready));
      chk("mdl_resp", W'(resp_o), W'(e_resp));
      chk("mdl_selerr", W'(selerr_o), W'(exp_pulse));
      if (owner == N && dflt_q.size() > 0) void'(dflt_q.pop_front());
      exp_pulse = 1'b0;
      if (e_ready) begin
        cnt = $countones(sel);
        idx = 0;
        for (int i = 0; i < N; i++) if (sel[i]) idx = i;
        if (!htrans[1]) begin
          owner = -1;
        end else if (cnt == 1) begin
          owner = idx;
        end else begin
          owner = N;
          dflt_q.push_back(2'b01);
          dflt_q.push_back(2'b11);
          exp_pulse = (cnt > 1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slave(input int i, input logic [W-1:0] d, input logic r, input logic e);
    rdata_in[i*W +: W] = d;
    rdy_in[i]          = r;
    resp_in[i]         = e;
  endtask

  task automatic look(input string name, input logic r, input logic e, input logic [W-1:0] d,
                      input logic se);
    #1;
    chk({name, "_ready"}, W'(ready_o), W'(r));
    chk({name, "_resp"}, W'(resp_o), W'(e));
    chk({name, "_rdata"}, rdata_o, d);
    chk({name, "_selerr"}, W'(selerr_o), W'(se));
  endtask

  task automatic slaves_default();
    for (int i = 0; i < N; i++) set_slave(i, 32'hA5A5_0000 | W'(i), 1'b1, 1'b0);
  endtask

  initial begin
    rstn   = 1'b1;
    sel    = '0;
    htrans = 2'b00;
    slaves_default();
    #1 rstn = 1'b0;
    repeat (3) step();
    rstn = 1'b1;
    look("reset_release", 1'b1, 1'b0, '0, 1'b0);

    // Single read from slave 2 with two wait states
    sel = 4'b0100; htrans = 2'b10;
    step();
    sel = '0; htrans = 2'b00; rdy_in[2] = 1'b0;
    look("rd_wait1", 1'b0, 1'b0, 32'hA5A5_0002, 1'b0);
    step();
    look("rd_wait2", 1'b0, 1'b0, 32'hA5A5_0002, 1'b0);
    step();
    rdy_in[2] = 1'b1;
    look("rd_done", 1'b1, 1'b0, 32'hA5A5_0002, 1'b0);
    step();

    // Pipelined zero-wait reads, slave 0 then slave 3
    set_slave(0, 32'h1111_0000, 1'b1, 1'b0);
    set_slave(3, 32'h3333_0003, 1'b1, 1'b0);
    sel = 4'b0001; htrans = 2'b10;
    step();
    sel = 4'b1000; htrans = 2'b11;
    look("pipe_s0", 1'b1, 1'b0, 32'h1111_0000, 1'b0);
    step();
    sel = '0; htrans = 2'b00;
    look("pipe_s3", 1'b1, 1'b0, 32'h3333_0003, 1'b0);
    step();

    // Unmapped address, next transfer held until end of second ERROR cycle
    sel = 4'b0000; htrans = 2'b10;
    step();
    sel = 4'b0010; htrans = 2'b10;
    set_slave(1, 32'h2222_0001, 1'b1, 1'b0);
    look("unm_c1", 1'b0, 1'b1, '0, 1'b0);
    step();
    look("unm_c2", 1'b1, 1'b1, '0, 1'b0);
    step();
    sel = '0; htrans = 2'b00;
    look("unm_next", 1'b1, 1'b0, 32'h2222_0001, 1'b0);
    step();

    // Multi-hot select on an active transfer, then on an IDLE transfer
    sel = 4'b0110; htrans = 2'b10;
    step();
    sel = '0; htrans = 2'b00;
    look("multi_c1", 1'b0, 1'b1, '0, 1'b1);
    step();
    look("multi_c2", 1'b1, 1'b1, '0, 1'b0);
    step();
    sel = 4'b0110; htrans = 2'b00;
    step();
    sel = '0;
    look("idle_multi", 1'b1, 1'b0, '0, 1'b0);
    step();

    // Slave 1 two-cycle ERROR passes through; IDLE ignores slave outputs
    sel = 4'b0010; htrans = 2'b10;
    step();
    sel = '0; htrans = 2'b00;
    set_slave(1, 32'h2222_00EE, 1'b0, 1'b1);
    look("serr_c1", 1'b0, 1'b1, 32'h2222_00EE, 1'b0);
    step();
    set_slave(1, 32'h2222_00EE, 1'b1, 1'b1);
    look("serr_c2", 1'b1, 1'b1, 32'h2222_00EE, 1'b0);
    step();
    set_slave(1, 32'h2222_0001, 1'b1, 1'b0);
    sel = 4'b0001; htrans = 2'b00;
    step();
    sel = '0;
    set_slave(0, 32'h1111_00EE, 1'b0, 1'b1);
    set_slave(1, 32'h2222_00EE, 1'b0, 1'b1);
    look("idle_ign", 1'b1, 1'b0, '0, 1'b0);
    step();
    slaves_default();

    // Asynchronous reset during a slave 2 wait state
    sel = 4'b0100; htrans = 2'b10;
    step();
    sel = '0; htrans = 2'b00; rdy_in[2] = 1'b0;
    look("rw_wait", 1'b0, 1'b0, 32'hA5A5_0002, 1'b0);
    #1 rstn = 1'b0;
    look("rst_async", 1'b1, 1'b0, '0, 1'b0);
    step();
    step();
    rstn = 1'b1;
    rdy_in[2] = 1'b1;
    step();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      htrans = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       sel = '0;
        3:       sel = N'($urandom);
        default: sel = N'(1 << $urandom_range(0, N - 1));
      endcase
      for (int i = 0; i < N; i++)
        set_slave(i, $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0));
      if (n == 1500) rstn = 1'b0;
      if (n == 1502) rstn = 1'b1;
      step();
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
